// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and flag bit positions for the nibble-serial ALU
//            flag unit.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        FM_KEEP = 3'd0,
        FM_CLR  = 3'd1,
        FM_SET  = 3'd2,
        FM_ALU  = 3'd3,
        FM_CPL  = 3'd4
    } fmode_t;

    typedef enum logic [1:0] {
        CI_ZERO = 2'd0,
        CI_ONE  = 2'd1,
        CI_FC   = 2'd2,
        CI_NFC  = 2'd3
    } ci_sel_t;

    typedef enum logic [1:0] {
        COND_NZ = 2'd0,
        COND_Z  = 2'd1,
        COND_NC = 2'd2,
        COND_C  = 2'd3
    } cond_t;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    // Only the upper nibble of F holds flags; the lower nibble reads as zero.
    localparam logic [7:0] F_MASK = 8'hF0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/flag_sel.sv
`default_nettype none
// ============================================================================
// Module   : flag_sel
// Brief    : Per-flag next-value mux selected by the latched update mode.
// Revision : 1.0
// ============================================================================
module flag_sel
    import alu_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       cur,
    input  logic       alu_val,
    output logic       nxt
);

    always_comb begin
        nxt = cur;
        case (fmode_t'(mode))
            FM_KEEP: nxt = cur;
            FM_CLR:  nxt = 1'b0;
            FM_SET:  nxt = 1'b1;
            FM_ALU:  nxt = alu_val;
            FM_CPL:  nxt = ~cur;
            default: nxt = cur;
        endcase
    end

endmodule : flag_sel
`default_nettype wire

// File: rtl/alu_flags.sv
`default_nettype none
// ============================================================================
// Module   : alu_flags
// Brief    : Flag unit behind the nibble-serial ALU: carry chaining between
//            nibbles, F register commit and branch condition evaluation.
// Revision : 1.0
// ============================================================================
module alu_flags
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       op_lo,
    input  logic       op_hi,
    input  logic       abort,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       sub,
    input  logic [1:0] ci_sel,
    input  logic [2:0] zmode,
    input  logic [2:0] nmode,
    input  logic [2:0] hmode,
    input  logic [2:0] cmode,
    input  logic       f_we,
    input  logic [7:0] f_din,
    input  logic [1:0] cond,
    output logic       alu_ci,
    output logic [7:0] f,
    output logic       busy,
    output logic       cond_true
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_latch;
    logic       w_commit;

    logic       r_hc_raw;
    logic       r_z_lo;
    logic       r_sub;
    logic [2:0] r_zmode;
    logic [2:0] r_nmode;
    logic [2:0] r_hmode;
    logic [2:0] r_cmode;
    logic [7:0] r_f;

    logic       w_z_nxt;
    logic       w_n_nxt;
    logic       w_h_nxt;
    logic       w_c_nxt;
    logic [7:0] w_f_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In HI, abort outranks a restarting op_lo, which outranks the commit.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_lo) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (op_lo) begin
                    w_latch = 1'b1;
                end else if (op_hi) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc_raw <= 1'b0;
            r_z_lo   <= 1'b0;
            r_sub    <= 1'b0;
            r_zmode  <= 3'd0;
            r_nmode  <= 3'd0;
            r_hmode  <= 3'd0;
            r_cmode  <= 3'd0;
        end else if (w_latch) begin
            r_hc_raw <= alu_carry;
            r_z_lo   <= alu_zero;
            r_sub    <= sub;
            r_zmode  <= zmode;
            r_nmode  <= nmode;
            r_hmode  <= hmode;
            r_cmode  <= cmode;
        end
    end

    // Raw adder carries become borrows on subtraction by inversion.
    flag_sel u_sel_z (.mode(r_zmode), .cur(r_f[FLAG_Z]), .alu_val(r_z_lo & alu_zero),   .nxt(w_z_nxt));
    flag_sel u_sel_n (.mode(r_nmode), .cur(r_f[FLAG_N]), .alu_val(r_sub),               .nxt(w_n_nxt));
    flag_sel u_sel_h (.mode(r_hmode), .cur(r_f[FLAG_H]), .alu_val(r_hc_raw ^ r_sub),    .nxt(w_h_nxt));
    flag_sel u_sel_c (.mode(r_cmode), .cur(r_f[FLAG_C]), .alu_val(alu_carry ^ r_sub),   .nxt(w_c_nxt));

    assign w_f_commit = {w_z_nxt, w_n_nxt, w_h_nxt, w_c_nxt, 4'b0000};

    // A direct write takes precedence over a same-cycle commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f <= 8'h00;
        end else if (f_we) begin
            r_f <= f_din & F_MASK;
        end else if (w_commit) begin
            r_f <= w_f_commit;
        end
    end

    always_comb begin
        alu_ci = 1'b0;
        if (r_state == ST_HI) begin
            alu_ci = r_hc_raw;
        end else begin
            case (ci_sel_t'(ci_sel))
                CI_ZERO: alu_ci = 1'b0;
                CI_ONE:  alu_ci = 1'b1;
                CI_FC:   alu_ci = r_f[FLAG_C];
                CI_NFC:  alu_ci = ~r_f[FLAG_C];
                default: alu_ci = 1'b0;
            endcase
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(cond))
            COND_NZ: cond_true = ~r_f[FLAG_Z];
            COND_Z:  cond_true = r_f[FLAG_Z];
            COND_NC: cond_true = ~r_f[FLAG_C];
            COND_C:  cond_true = r_f[FLAG_C];
            default: cond_true = 1'b0;
        endcase
    end

    assign f    = r_f;
    assign busy = (r_state == ST_HI);

endmodule : alu_flags
`default_nettype wire

// File: tb/tb_alu_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flags
// Brief    : Directed self-checking bench for alu_flags with an expected-value
//            queue.
// Revision : 1.0
// ============================================================================
module tb_alu_flags;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_lo, op_hi, abort;
    logic       alu_carry, alu_zero, sub;
    logic [1:0] ci_sel;
    logic [2:0] zmode, nmode, hmode, cmode;
    logic       f_we;
    logic [7:0] f_din;
    logic [1:0] cond;
    logic       alu_ci;
    logic [7:0] f;
    logic       busy;
    logic       cond_true;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    alu_flags dut (
        .clk(clk), .reset(reset), .op_lo(op_lo), .op_hi(op_hi), .abort(abort),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .sub(sub), .ci_sel(ci_sel),
        .zmode(zmode), .nmode(nmode), .hmode(hmode), .cmode(cmode),
        .f_we(f_we), .f_din(f_din), .cond(cond),
        .alu_ci(alu_ci), .f(f), .busy(busy), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_modes(input fmode_t z, input fmode_t n, input fmode_t h, input fmode_t c);
        zmode = z; nmode = n; hmode = h; cmode = c;
    endtask

    initial begin
        reset = 1'b1; op_lo = 0; op_hi = 0; abort = 0;
        alu_carry = 0; alu_zero = 0; sub = 0; ci_sel = CI_ZERO;
        set_modes(FM_ALU, FM_ALU, FM_ALU, FM_ALU);
        f_we = 0; f_din = 8'h00; cond = COND_NZ;
        step();
        push(8'h00); chk("reset_f", f);
        push(8'h00); chk("reset_busy", {7'b0, busy});
        reset = 1'b0;
        step();

        // NEG 0x01
        op_lo = 1; ci_sel = CI_ONE; alu_carry = 0; alu_zero = 0; sub = 1;
        #1;
        push(8'h01); chk("neg_ci_idle", {7'b0, alu_ci});
        step();
        op_lo = 0;
        push(8'h00); chk("neg_ci_hi", {7'b0, alu_ci});
        push(8'h01); chk("neg_busy", {7'b0, busy});
        op_hi = 1; alu_carry = 0; alu_zero = 0;
        step();
        op_hi = 0;
        push(8'h70); chk("neg_f", f);
        push(8'h00); chk("neg_busy_after", {7'b0, busy});

        // ADD 0x0F + 0x01
        op_lo = 1; ci_sel = CI_ZERO; alu_carry = 1; alu_zero = 1; sub = 0;
        step();
        op_lo = 0;
        push(8'h01); chk("add_ci_hi", {7'b0, alu_ci});
        op_hi = 1; alu_carry = 0; alu_zero = 0;
        step();
        op_hi = 0;
        push(8'h20); chk("add_f", f);

        // SUB 0x10 - 0x10
        op_lo = 1; alu_carry = 1; alu_zero = 1; sub = 1;
        step();
        op_lo = 0;
        op_hi = 1; alu_carry = 1; alu_zero = 1;
        step();
        op_hi = 0;
        push(8'hC0); chk("sub_f", f);
        cond = COND_Z;  #1; push(8'h01); chk("sub_cond_z", {7'b0, cond_true});
        cond = COND_NC; #1; push(8'h01); chk("sub_cond_nc", {7'b0, cond_true});
        cond = COND_NZ; #1; push(8'h00); chk("sub_cond_nz", {7'b0, cond_true});
        cond = COND_C;  #1; push(8'h00); chk("sub_cond_c", {7'b0, cond_true});

        // Abort between op_lo and op_hi
        op_lo = 1; alu_carry = 0; alu_zero = 0; sub = 0;
        step();
        op_lo = 0;
        push(8'h01); chk("abort_busy_hi", {7'b0, busy});
        abort = 1;
        step();
        abort = 0;
        push(8'h00); chk("abort_busy_lo", {7'b0, busy});
        push(8'hC0); chk("abort_f", f);
        op_hi = 1;
        step();
        op_hi = 0;
        push(8'hC0); chk("abort_late_hi_f", f);
        push(8'h00); chk("abort_late_hi_busy", {7'b0, busy});

        // Reset pulsed mid-op
        op_lo = 1; alu_carry = 0; alu_zero = 0; sub = 0;
        step();
        op_lo = 0;
        reset = 1;
        #1;
        push(8'h00); chk("rst_mid_f", f);
        push(8'h00); chk("rst_mid_busy", {7'b0, busy});
        #1;
        reset = 0;
        op_hi = 1; alu_carry = 1;
        step();
        op_hi = 0;
        push(8'h00); chk("rst_late_hi_f", f);

        // Direct F write, NFC carry-in, write vs commit
        f_we = 1; f_din = 8'hFF;
        step();
        f_we = 0;
        push(8'hF0); chk("fwe_f", f);
        ci_sel = CI_NFC; op_lo = 1; alu_carry = 0; alu_zero = 0; sub = 0;
        #1;
        push(8'h00); chk("fwe_nfc_ci", {7'b0, alu_ci});
        ci_sel = CI_FC; #1;
        push(8'h01); chk("fwe_fc_ci", {7'b0, alu_ci});
        step();
        op_lo = 0;
        op_hi = 1; f_we = 1; f_din = 8'hA5;
        step();
        op_hi = 0; f_we = 0;
        push(8'hA0); chk("fwe_vs_commit_f", f);
        push(8'h00); chk("fwe_vs_commit_busy", {7'b0, busy});

        // Restart in HI re-latches; input changes during HI are ignored
        op_lo = 1; alu_carry = 1; alu_zero = 1; sub = 0;
        step();
        alu_carry = 0; alu_zero = 0; sub = 1;
        step();
        op_lo = 0;
        push(8'h01); chk("restart_busy", {7'b0, busy});
        sub = 0; set_modes(FM_SET, FM_SET, FM_SET, FM_SET);
        op_hi = 1; alu_carry = 0; alu_zero = 0;
        step();
        op_hi = 0;
        push(8'h70); chk("restart_f", f);

        // CCF from 0x90
        f_we = 1; f_din = 8'h90;
        step();
        f_we = 0;
        set_modes(FM_KEEP, FM_CLR, FM_CLR, FM_CPL);
        for (int k = 0; k < 2; k++) begin
            op_lo = 1;
            step();
            op_lo = 0; op_hi = 1;
            step();
            op_hi = 0;
            push((k == 0) ? 8'h80 : 8'h90);
            chk((k == 0) ? "ccf_first" : "ccf_second", f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_flags
`default_nettype wire

// File: doc/alu_flags.md
Name: alu_flags

Overview:
- Flag unit directly downstream of the nibble-serial ALU.
- Consumes the ALU's per-nibble raw carry and zero outputs and latches the low-nibble carry between the two nibble cycles.
- Supplies the ALU carry-in for each nibble and commits Z/N/H/C into the F register at the end of the high-nibble cycle.
- Also evaluates branch conditions (NZ/Z/NC/C) for the sequencer.

Parameters:
- none (byte width 8, nibble width 4 fixed by the architecture)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- op_lo  in  1  low-nibble ALU cycle strobe; samples modes and low-nibble ALU outputs
- op_hi  in  1  high-nibble ALU cycle strobe; commits flags
- abort  in  1  cancel an in-flight op (interrupt/flush)
- alu_carry  in  1  raw adder carry-out of the current nibble (not borrow-corrected)
- alu_zero  in  1  current result nibble == 0
- sub  in  1  op is a subtraction; sampled at op_lo
- ci_sel  in  2  low-nibble carry-in select: CI_ZERO, CI_ONE, CI_FC, CI_NFC
- zmode, nmode, hmode, cmode  in  3 each  flag update mode, sampled at op_lo
- f_we  in  1  direct F write (POP AF)
- f_din  in  8  data for f_we
- cond  in  2  condition select: NZ, Z, NC, C
- alu_ci  out  1  carry-in to ALU for the current nibble
- f  out  8  {Z,N,H,C,4'b0000}
- busy  out  1  high while waiting for op_hi
- cond_true  out  1  combinational condition result from the committed f

Behaviour:
- Reset, asynchronous: f=8'h00, FSM=IDLE, busy=0, all latches 0.
- FSM states:
  - IDLE: op_lo -> HI. In the same edge, latch hc_raw=alu_carry, z_lo=alu_zero, sub and all four modes.
  - HI: op_hi -> commit, then IDLE. abort -> IDLE, no commit. op_lo -> restart: discard the old op, re-latch, stay in HI.
- Priority in HI: abort > op_lo > op_hi. In IDLE, op_hi and abort are ignored.
- alu_ci:
  - in HI, alu_ci = hc_raw.
  - in IDLE, decoded from ci_sel: CI_ZERO=0, CI_ONE=1, CI_FC=f[4], CI_NFC=!f[4].
- Commit values per flag by mode:
  - Mode encoding: FM_KEEP, FM_CLR, FM_SET, FM_ALU, FM_CPL.
  - ALU source: Z = z_lo & alu_zero; N = sub; H = hc_raw ^ sub; C = alu_carry ^ sub. Borrow is the inverted carry.
  - FM_CPL inverts the stored flag; used for CCF.
- Latency: flags are visible on f the cycle after the op_hi edge. cond_true reflects the new f at the same point.
- f_we writes f = {f_din[7:4],4'b0} in any state and does not change FSM state.
- f_we coincident with commit: f_we wins; the commit is dropped and the FSM still returns to IDLE.
- Low nibble of f is always 0, including after f_we with f_din[3:0]≠0.
- busy = (state==HI).
- Reset asserted mid-op: immediate return to IDLE, f cleared, no commit on later op_hi.
- Modes latched at op_lo are held; input changes during HI have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - fmode_t enum (KEEP, CLR, SET, ALU, CPL)
  - ci_sel_t enum
  - cond_t enum
  - flag bit index constants FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4
- One sub-module, flag_sel: a per-flag combinational mode mux, instantiated four times.
- FSM and latches live in the top.

Test Plan:
- NEG 0x01:
  - Stimulus: op_lo with ci_sel=CI_ONE, alu_carry=0, alu_zero=0, sub=1, all modes ALU; next cycle op_hi with alu_carry=0, alu_zero=0.
  - Required: alu_ci=1 in IDLE and 0 in HI; f=8'h70.
- ADD 0x0F+0x01:
  - Stimulus: op_lo with carry=1, zero=1, sub=0; op_hi with carry=0, zero=0.
  - Required: alu_ci=1 during HI; f=8'h20.
- SUB 0x10-0x10:
  - Stimulus: op_lo with carry=1, zero=1; op_hi with carry=1, zero=1; sub=1.
  - Required: f=8'hC0; cond=Z gives cond_true=1; cond=NC gives cond_true=1.
- Abort and reset:
  - Stimulus: abort between op_lo and op_hi.
  - Required: f unchanged, busy 1 -> 0, a later op_hi is ignored.
  - Repeat with reset pulsed mid-op. Required: f=00 immediately.
- f_we:
  - f_we with f_din=8'hFF -> f=8'hF0.
  - Then op_lo with ci_sel=CI_NFC -> alu_ci=0.
  - f_we together with the op_hi commit -> f_we value wins.
- CCF:
  - Stimulus: cmode=CPL, hmode=CLR, nmode=CLR, zmode=KEEP, starting from f=8'h90.
  - Required: f=8'h80. Repeat and require f=8'h90.
